// File: rtl/prio_enc_seg_ctrl.sv
// Debounced, registered priority encoder with live/hold capture, an 8-bit change counter
// and three active-low seven-segment digits (code on HEX0, count on HEX2:HEX1).
module prio_enc_seg_ctrl #(
    parameter  int N_IN       = 16,
    parameter  int STABLE_CYC = 4,
    localparam int W_OUT      = $clog2(N_IN)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [N_IN-1:0]   i_sw,
    input  logic              i_en,
    input  logic              i_mode,
    input  logic              i_clr,
    output logic [W_OUT-1:0]  o_code,
    output logic              o_valid,
    output logic              o_held,
    output logic [6:0]        o_hex0,
    output logic [6:0]        o_hex1,
    output logic [6:0]        o_hex2
);

    localparam int               CNT_W    = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYC - 1);

    typedef enum logic [1:0] {
        ST_LIVE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_HELD  = 2'd2
    } state_t;

    logic [N_IN-1:0]  r_sample;
    logic [CNT_W-1:0] r_dbCnt;
    logic [N_IN-1:0]  r_accepted;

    state_t           r_state;
    logic [W_OUT-1:0] r_code;
    logic             r_valid;
    logic             r_held;
    logic [7:0]       r_count;

    logic [W_OUT-1:0] w_encIndex;
    logic [W_OUT-1:0] w_encCode;
    logic             w_encValid;
    logic             w_countInc;
    logic [3:0]       w_codeNibble;

    // Any change on the switches restarts the stability window.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sample   <= '0;
            r_dbCnt    <= '0;
            r_accepted <= '0;
        end else if (i_sw != r_sample) begin
            r_sample <= i_sw;
            r_dbCnt  <= '0;
        end else if (r_dbCnt == CNT_LAST) begin
            r_accepted <= r_sample;
        end else begin
            r_dbCnt <= r_dbCnt + CNT_W'(1);
        end
    end

    always_comb begin
        w_encIndex = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (r_accepted[i]) begin
                w_encIndex = W_OUT'(i);
            end
        end
    end

    assign w_encValid = i_en && (r_accepted != '0);
    assign w_encCode  = w_encValid ? w_encIndex : '0;

    // A fresh code is counted only while the outputs are not frozen.
    assign w_countInc = (r_state != ST_HELD) && w_encValid &&
                        (!r_valid || (w_encCode != r_code));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_LIVE;
            r_code  <= '0;
            r_valid <= 1'b0;
            r_held  <= 1'b0;
            r_count <= 8'd0;
        end else begin
            if (i_clr) begin
                r_count <= 8'd0;
            end else if (w_countInc) begin
                r_count <= r_count + 8'd1;
            end

            if (!i_mode) begin
                r_state <= ST_LIVE;
                r_held  <= 1'b0;
                r_code  <= w_encCode;
                r_valid <= w_encValid;
            end else begin
                case (r_state)
                    ST_LIVE: begin
                        r_state <= ST_ARMED;
                        r_code  <= w_encCode;
                        r_valid <= w_encValid;
                    end
                    ST_ARMED: begin
                        r_code  <= w_encCode;
                        r_valid <= w_encValid;
                        if (w_encValid) begin
                            r_state <= ST_HELD;
                            r_held  <= 1'b1;
                        end
                    end
                    ST_HELD: begin
                        if (i_clr) begin
                            r_state <= ST_ARMED;
                            r_held  <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= ST_LIVE;
                        r_held  <= 1'b0;
                    end
                endcase
            end
        end
    end

    function automatic logic [6:0] segDecode(input logic [3:0] value);
        logic [6:0] seg;
        case (value)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    assign w_codeNibble = 4'(r_code);

    assign o_code  = r_code;
    assign o_valid = r_valid;
    assign o_held  = r_held;
    assign o_hex0  = r_valid ? segDecode(w_codeNibble) : 7'h7F;
    assign o_hex1  = segDecode(r_count[3:0]);
    assign o_hex2  = segDecode(r_count[7:4]);

endmodule
